// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// This package also provides the branch-offset sign-extension helper.
package fetch_pkg;

    localparam int          PC_W_DEF      = 32;
    localparam logic [31:0] HALT_INST_DEF = 32'h00010003;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Sign-extends to 64 bits so callers can narrow it to any PC width up to 64.
    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register for instruction, return PC and valid bit.
// load captures new contents, flush clears valid, and neither holds everything.
module ifid_reg #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [31:0]     inst_i,
    input  logic [PC_W-1:0] pc_i,
    output logic [31:0]     inst_o,
    output logic [PC_W-1:0] pc_o,
    output logic            valid_o
);

    logic [31:0]     inst_q;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, handles stall, branch redirect, halt detection and
// out-of-range faults, and feeds the IF/ID register.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          PC_W       = PC_W_DEF,
    parameter int          IMEM_DEPTH = 32,
    parameter logic [31:0] HALT_INST  = HALT_INST_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] pcout,
    input  logic [31:0]     inst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    output logic [31:0]     ifid_inst,
    output logic [PC_W-1:0] ifid_pc,
    output logic            ifid_valid,
    output logic            halted,
    output logic            fault,
    output fetch_state_e    state_dbg
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_target;
    logic            pc_oor;
    logic            is_halt;
    logic            ifid_load;
    logic            ifid_flush;

    assign pc_inc    = pc_q + PC_W'(1);
    assign br_target = ifid_pc + PC_W'(sext16(branch_offset));
    assign pc_oor    = (pc_q >= PC_W'(IMEM_DEPTH));
    assign is_halt   = (inst == HALT_INST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A branch or stall masks the fault/halt checks of the current fetch.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && !branch_taken && !stall) begin
            if (pc_oor) begin
                state_d = ST_FAULT;
            end else if (is_halt) begin
                state_d = ST_HALT;
            end
        end
    end

    always_comb begin
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d       = br_target;
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    ifid_flush = 1'b0;
                end else if (pc_oor || is_halt) begin
                    ifid_flush = 1'b1;
                end else begin
                    pc_d      = pc_inc;
                    ifid_load = 1'b1;
                end
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    ifid_reg #(.PC_W(PC_W)) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .inst_i  (inst),
        .pc_i    (pc_inc),
        .inst_o  (ifid_inst),
        .pc_o    (ifid_pc),
        .valid_o (ifid_valid)
    );

    assign pcout     = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign fault     = (state_q == ST_FAULT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small behavioural instruction memory.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    logic         clk;
    logic         reset;
    logic [31:0]  pcout;
    logic [31:0]  inst;
    logic         stall;
    logic         branch_taken;
    logic [15:0]  branch_offset;
    logic [31:0]  ifid_inst;
    logic [31:0]  ifid_pc;
    logic         ifid_valid;
    logic         halted;
    logic         fault;
    fetch_state_e state_dbg;

    logic [31:0] mem [0:63];
    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pcout         (pcout),
        .inst          (inst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .ifid_inst     (ifid_inst),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fault         (fault),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign inst = (pcout < 32'd64) ? mem[pcout[5:0]] : 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                          input logic [31:0] iinst, input logic valid);
        check({tag, ".pcout"}, 64'(pcout), 64'(pc));
        check({tag, ".ifid_pc"}, 64'(ifid_pc), 64'(ipc));
        check({tag, ".ifid_inst"}, 64'(ifid_inst), 64'(iinst));
        check({tag, ".ifid_valid"}, 64'(ifid_valid), 64'(valid));
    endtask

    task automatic chk_flags(input string tag, input logic h, input logic f, input fetch_state_e st);
        check({tag, ".halted"}, 64'(halted), 64'(h));
        check({tag, ".fault"}, 64'(fault), 64'(f));
        check({tag, ".state"}, 64'(state_dbg), 64'(st));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[20] = 32'h00010003;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
        step(); step();
        chk_if("reset", 32'd0, 32'd0, 32'd0, 1'b0);
        chk_flags("reset", 1'b0, 1'b0, ST_RUN);

        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_if($sformatf("run%0d", k), 32'(k), 32'(k), 32'hC0DE_0000 | 32'(k - 1), 1'b1);
        end

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_if($sformatf("stall%0d", k), 32'd4, 32'd4, 32'hC0DE_0003, 1'b1);
        end
        stall = 1'b0;

        for (int k = 5; k <= 7; k++) begin
            step();
            chk_if($sformatf("resume%0d", k), 32'(k), 32'(k), 32'hC0DE_0000 | 32'(k - 1), 1'b1);
        end

        // Branch beats stall: 7 + 13 = 20.
        branch_taken = 1'b1; stall = 1'b1; branch_offset = 16'd13;
        step();
        chk_if("br_pos", 32'd20, 32'd7, 32'hC0DE_0006, 1'b0);
        stall = 1'b0;

        branch_offset = 16'hFFFD;
        step();
        chk_if("br_neg", 32'd4, 32'd7, 32'hC0DE_0006, 1'b0);

        branch_offset = 16'd13;
        step();
        check("br_to20.pcout", 64'(pcout), 64'd20);

        // Halt word at 20 is present, but the branch suppresses it.
        branch_offset = 16'hFFFE;
        step();
        check("br_over_halt.pcout", 64'(pcout), 64'd5);
        chk_flags("br_over_halt", 1'b0, 1'b0, ST_RUN);

        branch_offset = 16'd13;
        step();
        check("br_to20b.pcout", 64'(pcout), 64'd20);

        branch_taken = 1'b0;
        step();
        chk_if("halt", 32'd20, 32'd7, 32'hC0DE_0006, 1'b0);
        chk_flags("halt", 1'b1, 1'b0, ST_HALT);

        branch_taken = 1'b1; branch_offset = 16'hFFFD;
        step();
        chk_if("halt_br", 32'd20, 32'd7, 32'hC0DE_0006, 1'b0);
        branch_taken = 1'b0; stall = 1'b1;
        step();
        check("halt_stall.pcout", 64'(pcout), 64'd20);
        stall = 1'b0;
        step();
        check("halt_idle.pcout", 64'(pcout), 64'd20);
        chk_flags("halt_idle", 1'b1, 1'b0, ST_HALT);

        reset = 1'b1;
        step();
        chk_if("rst_halt", 32'd0, 32'd0, 32'd0, 1'b0);
        chk_flags("rst_halt", 1'b0, 1'b0, ST_RUN);
        reset = 1'b0;
        step();
        chk_if("restart1", 32'd1, 32'd1, 32'hC0DE_0000, 1'b1);

        // 1 + 39 = 40, beyond the 32-word memory.
        branch_taken = 1'b1; branch_offset = 16'd39;
        step();
        chk_if("br_oor", 32'd40, 32'd1, 32'hC0DE_0000, 1'b0);
        chk_flags("br_oor", 1'b0, 1'b0, ST_RUN);
        branch_taken = 1'b0; stall = 1'b1;
        step();
        check("oor_stall.pcout", 64'(pcout), 64'd40);
        check("oor_stall.fault", 64'(fault), 64'd0);
        stall = 1'b0;
        step();
        check("fault.pcout", 64'(pcout), 64'd40);
        check("fault.valid", 64'(ifid_valid), 64'd0);
        chk_flags("fault", 1'b0, 1'b1, ST_FAULT);

        branch_taken = 1'b1; branch_offset = 16'hFFFD;
        step();
        check("fault_br.pcout", 64'(pcout), 64'd40);
        chk_flags("fault_br", 1'b0, 1'b1, ST_FAULT);
        branch_taken = 1'b0;

        reset = 1'b1;
        step();
        chk_if("rst_fault", 32'd0, 32'd0, 32'd0, 1'b0);
        chk_flags("rst_fault", 1'b0, 1'b0, ST_RUN);
        reset = 1'b0;
        step();
        chk_if("restart2", 32'd1, 32'd1, 32'hC0DE_0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives it as a word index on pcout. It captures the returned instruction into an IF/ID pipeline register for the decoder. It also handles stall, branch redirect/flush, halt-instruction detection and out-of-range PC faults.

Parameters:
PC_W, 32, width of the program counter and of pcout / ifid_pc
IMEM_DEPTH, 32, number of instruction words; valid PC range is 0..IMEM_DEPTH-1
HALT_INST, 32'h00010003, encoding of the FINISH instruction that stops fetch

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
pcout  output  PC_W  word index presented to the instruction memory
inst  input  32  instruction word for pcout, combinational from memory in the same cycle
stall  input  1  hold request from downstream (hazard)
branch_taken  input  1  redirect request for the instruction currently in IF/ID
branch_offset  input  16  signed word offset, relative to ifid_pc
ifid_inst  output  32  registered instruction to decode
ifid_pc  output  PC_W  registered pcout+1 of the fetched instruction
ifid_valid  output  1  IF/ID contents are a real instruction
halted  output  1  HALT_INST was fetched; fetch has stopped
fault  output  1  fetch was attempted with pcout >= IMEM_DEPTH

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Reset overrides every other input on that edge.
- Reset values: pcout=0, ifid_inst=0, ifid_pc=0, ifid_valid=0, halted=0, fault=0, state=RUN.
- States: RUN, HALT, FAULT. HALT and FAULT are terminal until reset.
- Each RUN edge takes exactly one action, checked in this priority order:
  1. branch_taken=1:
     - pcout <= ifid_pc + sign_extend(branch_offset), with PC_W-bit wrap-around.
     - ifid_valid <= 0, flushing the wrong-path fetch.
     - ifid_inst and ifid_pc hold.
     - Halt and fault checks of the current inst/pcout are suppressed.
  2. stall=1:
     - pcout, ifid_inst, ifid_pc and ifid_valid all hold.
  3. pcout >= IMEM_DEPTH:
     - state -> FAULT, fault <= 1, ifid_valid <= 0, pcout holds.
  4. inst == HALT_INST:
     - state -> HALT, halted <= 1, ifid_valid <= 0.
     - The halt instruction is not forwarded; pcout holds.
  5. Otherwise:
     - ifid_inst <= inst, ifid_pc <= pcout+1, ifid_valid <= 1, pcout <= pcout+1.
- Latency: one cycle from pcout to the IF/ID registers. A branch redirect costs one bubble.
- Out-of-range branch target: pcout is loaded unchanged; the fault is raised at the next non-stalled fetch.
- HALT/FAULT states:
  - All inputs except reset are ignored.
  - ifid_valid stays 0; pcout, halted and fault hold.
- PC increment wraps modulo 2^PC_W. The fault check catches the wrap before any use.
- The block instantiates no memory; inst is sampled only at the clock edge.

Decomposition:
- fetch_pkg holds:
  - the state enum {RUN, HALT, FAULT};
  - the HALT_INST default constant;
  - the PC_W default;
  - a function for the 16-to-PC_W sign extension.
- One sub-module, ifid_reg: the IF/ID register with load, hold (stall) and flush (clear valid) controls and the synchronous reset.
- PC register and state machine stay in pc_fetch_unit.

Test Plan:
- Reset then 6 free-running cycles, memory words 0..5 non-halt:
  - pcout goes 0,1,2,3,4,5,6.
  - ifid_pc goes 1..6 with ifid_valid=1 from the first edge.
  - ifid_inst matches the memory words.
- stall=1 for 3 cycles at pcout=4: pcout, ifid_inst and ifid_pc frozen, ifid_valid unchanged; fetch resumes at 4 after release.
- Branch with ifid_pc=7, branch_offset=16'd13, asserted together with stall=1:
  - branch wins; next pcout=20, ifid_valid=0 for one cycle.
  - Negative case: branch_offset=16'hFFFD from ifid_pc=7 gives pcout=4.
- Memory word 20 = 32'h00010003, fetched at pcout=20:
  - halted=1, ifid_valid=0, pcout stays 20.
  - Later branch/stall pulses have no effect.
  - Same fetch with branch_taken=1 in that cycle: no halt, redirect taken.
- Branch to target 40 (IMEM_DEPTH=32): pcout=40, then fault=1 on the next edge; pcout stays 40; halted=0.
- reset asserted while halted and while faulted: every output returns to its reset value on that edge, and fetch restarts from 0.
